// File: rtl/bomberman_pkg.sv
// Shared types for the arena game: phase encodings, round outcome codes and
// the outcome/score helper functions used by the match sequencer.
package bomberman_pkg;

  localparam int HEALTH_W = 2;
  localparam int TIMER_W  = 7;
  localparam int SCORE_W  = 2;

  localparam logic [HEALTH_W-1:0] HEALTH_DEAD = 2'd0;
  localparam logic [SCORE_W-1:0]  SCORE_MAX   = 2'd3;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_CLEAR     = 3'd1,
    PH_COUNTDOWN = 3'd2,
    PH_PLAY      = 3'd3,
    PH_ROUND_END = 3'd4,
    PH_MATCH_END = 3'd5,
    PH_PAUSED    = 3'd6
  } phase_e;

  typedef enum logic [1:0] {
    GS_NONE  = 2'b00,
    GS_A_WIN = 2'b01,
    GS_B_WIN = 2'b10,
    GS_DRAW  = 2'b11
  } gameState_e;

  // Knock-outs outrank a simultaneous time expiry; on expiry the healthier player wins.
  function automatic gameState_e roundOutcome(input logic [HEALTH_W-1:0] hpA,
                                              input logic [HEALTH_W-1:0] hpB,
                                              input logic                expired);
    gameState_e res;
    if ((hpA == HEALTH_DEAD) && (hpB == HEALTH_DEAD)) begin
      res = GS_DRAW;
    end else if (hpA == HEALTH_DEAD) begin
      res = GS_B_WIN;
    end else if (hpB == HEALTH_DEAD) begin
      res = GS_A_WIN;
    end else if (!expired) begin
      res = GS_NONE;
    end else if (hpA > hpB) begin
      res = GS_A_WIN;
    end else if (hpB > hpA) begin
      res = GS_B_WIN;
    end else begin
      res = GS_DRAW;
    end
    return res;
  endfunction

  function automatic logic [SCORE_W-1:0] scoreInc(input logic [SCORE_W-1:0] score);
    logic [SCORE_W-1:0] res;
    if (score == SCORE_MAX) begin
      res = score;
    end else begin
      res = score + 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/match_sequencer_checker.sv
// Invariants of the match sequencer's registered outputs against its phase.
// Pause state (phase 6) is legal only with MATCH_SEQUENCER_PAUSE_EN defined.
module match_sequencer_checker
  import bomberman_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic [2:0] phase,
  input logic       arenaRst,
  input logic       playEn,
  input logic       matchOver
);

  a_play_phase: assert property (@(posedge clk) disable iff (rst)
    playEn == (phase == PH_PLAY))
    else $error("play_en disagrees with phase %0d", phase);

  a_clear_phase: assert property (@(posedge clk) disable iff (rst)
    arenaRst == (phase == PH_CLEAR))
    else $error("arena_rst disagrees with phase %0d", phase);

  a_match_phase: assert property (@(posedge clk) disable iff (rst)
    matchOver == (phase == PH_MATCH_END))
    else $error("match_over disagrees with phase %0d", phase);

`ifdef MATCH_SEQUENCER_PAUSE_EN
  a_phase_legal: assert property (@(posedge clk) disable iff (rst)
    phase != 3'd7)
    else $error("illegal phase %0d", phase);
`else
  a_phase_legal: assert property (@(posedge clk) disable iff (rst)
    phase <= 3'd5)
    else $error("illegal phase %0d", phase);
`endif

endmodule

// File: rtl/sec_down_counter.sv
// Loadable seconds down-counter shared by the countdown, round and hold timers.
// terminal flags a tick that takes the count from 1 to 0.
module sec_down_counter
  import bomberman_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadVal,
  input  logic               tick,
  input  logic               freeze,
  output logic [TIMER_W-1:0] count,
  output logic               terminal
);

  localparam logic [TIMER_W-1:0] CNT_ZERO = 7'd0;
  localparam logic [TIMER_W-1:0] CNT_ONE  = 7'd1;

  // Count register: load wins over tick, and the count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= CNT_ZERO;
    end else if (load) begin
      count <= loadVal;
    end else if (tick && !freeze && (count != CNT_ZERO)) begin
      count <= count - CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign terminal = tick & ~freeze & (count == CNT_ONE);

endmodule

// File: rtl/match_sequencer.sv
// Round/match controller for the two-player arena game. Defining
// MATCH_SEQUENCER_PAUSE_EN adds a start-button pause during PLAY.
module match_sequencer
  import bomberman_pkg::*;
#(
  parameter int COUNTDOWN_SEC = 3,
  parameter int ROUND_SEC     = 99,
  parameter int HOLD_SEC      = 2,
  parameter int WIN_ROUNDS    = 2,
  parameter int CLEAR_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sec_tick,
  input  logic [1:0] healthA,
  input  logic [1:0] healthB,
  output logic       arena_rst,
  output logic       play_en,
  output logic [2:0] phase,
  output logic [6:0] timer,
  output logic [1:0] game_state,
  output logic [1:0] scoreA,
  output logic [1:0] scoreB,
  output logic       match_over
);

  localparam logic [TIMER_W-1:0] COUNTDOWN_LD = TIMER_W'(COUNTDOWN_SEC);
  localparam logic [TIMER_W-1:0] ROUND_LD     = TIMER_W'(ROUND_SEC);
  localparam logic [TIMER_W-1:0] HOLD_LD      = TIMER_W'(HOLD_SEC);
  localparam logic [TIMER_W-1:0] TIMER_ZERO   = 7'd0;
  localparam logic [3:0]         CLEAR_LAST   = 4'(CLEAR_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_LD       = SCORE_W'(WIN_ROUNDS);

  phase_e             state_r;
  phase_e             nextState_s;
  gameState_e         gameState_r;
  gameState_e         nextGameState_s;
  gameState_e         outcome_s;
  logic [SCORE_W-1:0] scoreA_r;
  logic [SCORE_W-1:0] scoreB_r;
  logic [SCORE_W-1:0] nextScoreA_s;
  logic [SCORE_W-1:0] nextScoreB_s;
  logic [3:0]         clrCnt_r;
  logic [3:0]         nextClrCnt_s;
  logic               arenaRst_r;
  logic               playEn_r;
  logic               matchOver_r;
  logic               startArm_r;
  logic               startEdge_s;
  logic               cntLoad_s;
  logic [TIMER_W-1:0] cntLoadVal_s;
  logic               cntFreeze_s;
  logic [TIMER_W-1:0] timerCnt_s;
  logic               timerDone_s;

  // startArm_r means "start was low last cycle"; clearing it on reset makes a
  // button held through reset release count as no edge.
  assign startEdge_s = start & startArm_r;

  assign cntFreeze_s = ~((state_r == PH_COUNTDOWN) | (state_r == PH_PLAY) |
                         (state_r == PH_ROUND_END));

  assign outcome_s = roundOutcome(healthA, healthB, timerDone_s);

  sec_down_counter uSecTimer (
    .clk      (clk),
    .rst      (rst),
    .load     (cntLoad_s),
    .loadVal  (cntLoadVal_s),
    .tick     (sec_tick),
    .freeze   (cntFreeze_s),
    .count    (timerCnt_s),
    .terminal (timerDone_s)
  );

  // Next-state, timer load and score/outcome update decisions.
  always_comb begin
    nextState_s     = state_r;
    nextClrCnt_s    = 4'd0;
    nextGameState_s = gameState_r;
    nextScoreA_s    = scoreA_r;
    nextScoreB_s    = scoreB_r;
    cntLoad_s       = 1'b0;
    cntLoadVal_s    = TIMER_ZERO;
    case (state_r)
      PH_IDLE: begin
        if (startEdge_s) begin
          nextState_s     = PH_CLEAR;
          nextGameState_s = GS_NONE;
        end else begin
          nextState_s = PH_IDLE;
        end
      end
      PH_CLEAR: begin
        if (clrCnt_r == CLEAR_LAST) begin
          nextState_s  = PH_COUNTDOWN;
          cntLoad_s    = 1'b1;
          cntLoadVal_s = COUNTDOWN_LD;
        end else begin
          nextState_s  = PH_CLEAR;
          nextClrCnt_s = clrCnt_r + 4'd1;
        end
      end
      PH_COUNTDOWN: begin
        if (timerDone_s) begin
          nextState_s  = PH_PLAY;
          cntLoad_s    = 1'b1;
          cntLoadVal_s = ROUND_LD;
        end else begin
          nextState_s = PH_COUNTDOWN;
        end
      end
      PH_PLAY: begin
        // An outcome in the same cycle as a pause press takes precedence.
        if (outcome_s != GS_NONE) begin
          nextState_s     = PH_ROUND_END;
          nextGameState_s = outcome_s;
          cntLoad_s       = 1'b1;
          cntLoadVal_s    = HOLD_LD;
          if (outcome_s == GS_A_WIN) begin
            nextScoreA_s = scoreInc(scoreA_r);
          end else begin
            nextScoreA_s = scoreA_r;
          end
          if (outcome_s == GS_B_WIN) begin
            nextScoreB_s = scoreInc(scoreB_r);
          end else begin
            nextScoreB_s = scoreB_r;
          end
        end
`ifdef MATCH_SEQUENCER_PAUSE_EN
        else if (startEdge_s) begin
          nextState_s = PH_PAUSED;
        end
`endif
        else begin
          nextState_s = PH_PLAY;
        end
      end
      PH_ROUND_END: begin
        if (timerDone_s) begin
          if ((scoreA_r >= WIN_LD) || (scoreB_r >= WIN_LD)) begin
            nextState_s  = PH_MATCH_END;
            cntLoad_s    = 1'b1;
            cntLoadVal_s = TIMER_ZERO;
          end else begin
            nextState_s     = PH_CLEAR;
            nextGameState_s = GS_NONE;
          end
        end else begin
          nextState_s = PH_ROUND_END;
        end
      end
      PH_MATCH_END: begin
        if (startEdge_s) begin
          nextState_s     = PH_CLEAR;
          nextGameState_s = GS_NONE;
          nextScoreA_s    = 2'd0;
          nextScoreB_s    = 2'd0;
        end else begin
          nextState_s = PH_MATCH_END;
        end
      end
`ifdef MATCH_SEQUENCER_PAUSE_EN
      PH_PAUSED: begin
        if (startEdge_s) begin
          nextState_s = PH_PLAY;
        end else begin
          nextState_s = PH_PAUSED;
        end
      end
`endif
      default: begin
        nextState_s = PH_IDLE;
      end
    endcase
  end

  // State and output registers; outputs follow the state entered on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= PH_IDLE;
      clrCnt_r    <= 4'd0;
      gameState_r <= GS_NONE;
      scoreA_r    <= 2'd0;
      scoreB_r    <= 2'd0;
      arenaRst_r  <= 1'b0;
      playEn_r    <= 1'b0;
      matchOver_r <= 1'b0;
      startArm_r  <= 1'b0;
    end else begin
      state_r     <= nextState_s;
      clrCnt_r    <= nextClrCnt_s;
      gameState_r <= nextGameState_s;
      scoreA_r    <= nextScoreA_s;
      scoreB_r    <= nextScoreB_s;
      arenaRst_r  <= (nextState_s == PH_CLEAR);
      playEn_r    <= (nextState_s == PH_PLAY);
      matchOver_r <= (nextState_s == PH_MATCH_END);
      startArm_r  <= ~start;
    end
  end

  assign phase      = state_r;
  assign timer      = timerCnt_s;
  assign game_state = gameState_r;
  assign scoreA     = scoreA_r;
  assign scoreB     = scoreB_r;
  assign arena_rst  = arenaRst_r;
  assign play_en    = playEn_r;
  assign match_over = matchOver_r;

  match_sequencer_checker uChecker (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .arenaRst  (arenaRst_r),
    .playEn    (playEn_r),
    .matchOver (matchOver_r)
  );

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: directed scenarios plus a randomized run checked
// against a behavioural round/match model.
module tb_match_sequencer;

  localparam int CD = 3;
  localparam int RS = 99;
  localparam int HS = 2;
  localparam int WR = 2;
  localparam int CC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sec_tick = 1'b0;
  logic [1:0] healthA = 2'd3;
  logic [1:0] healthB = 2'd3;
  logic       arena_rst, play_en, match_over;
  logic [2:0] phase;
  logic [6:0] timer;
  logic [1:0] game_state, scoreA, scoreB;

  int total = 0;
  int bad = 0;

  // Model: phase number, seconds left, outcome code, scores, clear cycles left.
  int mPhase, mTimer, mGs, mA, mB, mClrLeft;
  bit mArm;

  match_sequencer #(
    .COUNTDOWN_SEC(CD), .ROUND_SEC(RS), .HOLD_SEC(HS),
    .WIN_ROUNDS(WR), .CLEAR_CYCLES(CC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sec_tick(sec_tick),
    .healthA(healthA), .healthB(healthB), .arena_rst(arena_rst),
    .play_en(play_en), .phase(phase), .timer(timer),
    .game_state(game_state), .scoreA(scoreA), .scoreB(scoreB),
    .match_over(match_over)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mPhase = 0; mTimer = 0; mGs = 0; mA = 0; mB = 0; mClrLeft = 0; mArm = 1'b0;
  endtask

  task automatic enter_clear();
    mPhase = 1; mClrLeft = CC; mGs = 0;
  endtask

  task automatic model_step();
    bit pressed;
    int o;
    pressed = start && mArm;
    if (rst) begin
      model_reset();
    end else begin
      mArm = !start;
      case (mPhase)
        0: if (pressed) enter_clear();
        1: begin
          mClrLeft = mClrLeft - 1;
          if (mClrLeft == 0) begin mPhase = 2; mTimer = CD; end
        end
        2: if (sec_tick) begin
          if (mTimer == 1) begin mPhase = 3; mTimer = RS; end
          else if (mTimer > 0) mTimer = mTimer - 1;
        end
        3: begin
          o = 0;
          if (healthA == 0 && healthB == 0) o = 3;
          else if (healthA == 0) o = 2;
          else if (healthB == 0) o = 1;
          else if (sec_tick && mTimer == 1)
            o = (healthA > healthB) ? 1 : ((healthB > healthA) ? 2 : 3);
          if (o != 0) begin
            mGs = o;
            if (o == 1 && mA < 3) mA = mA + 1;
            if (o == 2 && mB < 3) mB = mB + 1;
            mTimer = HS;
            mPhase = 4;
          end else begin
            if (sec_tick && mTimer > 0) mTimer = mTimer - 1;
`ifdef MATCH_SEQUENCER_PAUSE_EN
            if (pressed) mPhase = 6;
`endif
          end
        end
        4: if (sec_tick) begin
          if (mTimer == 1) begin
            mTimer = 0;
            if (mA >= WR || mB >= WR) mPhase = 5;
            else enter_clear();
          end else if (mTimer > 0) mTimer = mTimer - 1;
        end
        5: if (pressed) begin mA = 0; mB = 0; enter_clear(); end
        6: if (pressed) mPhase = 3;
        default: mPhase = 0;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin sec_tick = 1'b1; cyc(); end
    sec_tick = 1'b0;
  endtask

  task automatic go_to_play();
    for (int k = 0; k < 200 && mPhase != 3; k++) begin
      sec_tick = (mPhase == 2);
      cyc();
    end
    sec_tick = 1'b0;
    total++;
    if (phase !== 3'd3 || play_en !== 1'b1 || timer !== 7'(mTimer)) begin
      bad++;
      $display("FAIL reach_play: phase=%0d play_en=%0d timer=%0d, want phase=3 play_en=1 timer=%0d",
               phase, play_en, timer, mTimer);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    model_reset();
    repeat (3) cyc();
    total++;
    if (phase !== 3'd0 || arena_rst !== 1'b0 || play_en !== 1'b0 || match_over !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: phase=%0d arena=%0d play=%0d mo=%0d, want all 0",
               phase, arena_rst, play_en, match_over);
    end
    total++;
    if (timer !== 7'd0 || game_state !== 2'b00 || scoreA !== 2'd0 || scoreB !== 2'd0) begin
      bad++;
      $display("FAIL reset_data: timer=%0d gs=%0d A=%0d B=%0d, want all 0",
               timer, game_state, scoreA, scoreB);
    end
    start = 1'b1;
    rst = 1'b0;
    repeat (3) cyc();
    total++;
    if (phase !== 3'd0) begin
      bad++;
      $display("FAIL reset_held_start: phase=%0d want 0", phase);
    end
    start = 1'b0;
    cyc();
  endtask

  task automatic test_start_clear();
    int n;
    pulse_start();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (arena_rst === 1'b1) n++;
      cyc();
    end
    total++;
    if (n != CC) begin
      bad++;
      $display("FAIL clear_len: arena_rst high %0d cycles, want %0d", n, CC);
    end
    total++;
    if (phase !== 3'd2 || timer !== 7'd3 || play_en !== 1'b0) begin
      bad++;
      $display("FAIL countdown_load: phase=%0d timer=%0d play=%0d, want 2/3/0", phase, timer, play_en);
    end
    for (int i = 0; i < 3; i++) begin
      sec_tick = 1'b1; cyc(); sec_tick = 1'b0; cyc();
    end
    total++;
    if (play_en !== 1'b1 || timer !== 7'd99 || phase !== 3'd3) begin
      bad++;
      $display("FAIL play_entry: play=%0d timer=%0d phase=%0d, want 1/99/3", play_en, timer, phase);
    end
  endtask

  task automatic test_knockout();
    healthB = 2'd0; cyc(); healthB = 2'd3;
    total++;
    if (game_state !== 2'b01 || scoreA !== 2'd1 || play_en !== 1'b0 || timer !== 7'd2 || phase !== 3'd4) begin
      bad++;
      $display("FAIL ko_b: gs=%0d A=%0d play=%0d timer=%0d phase=%0d, want 1/1/0/2/4",
               game_state, scoreA, play_en, timer, phase);
    end
    ticks(2);
    total++;
    if (phase !== 3'd1 || arena_rst !== 1'b1 || game_state !== 2'b00) begin
      bad++;
      $display("FAIL ko_restart: phase=%0d arena=%0d gs=%0d, want 1/1/0", phase, arena_rst, game_state);
    end
  endtask

  task automatic test_double_ko();
    go_to_play();
    ticks(RS - 1);
    total++;
    if (timer !== 7'd1) begin
      bad++;
      $display("FAIL dko_pre: timer=%0d want 1", timer);
    end
    healthA = 2'd0; healthB = 2'd0; sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0; healthA = 2'd3; healthB = 2'd3;
    total++;
    if (game_state !== 2'b11 || scoreA !== 2'd1 || scoreB !== 2'd0 || timer !== 7'd2) begin
      bad++;
      $display("FAIL dko_draw: gs=%0d A=%0d B=%0d timer=%0d, want 3/1/0/2",
               game_state, scoreA, scoreB, timer);
    end
    ticks(2);
  endtask

  task automatic test_timeout_match();
    go_to_play();
    healthA = 2'd3; healthB = 2'd1;
    ticks(RS);
    total++;
    if (game_state !== 2'b01 || scoreA !== 2'd2 || phase !== 3'd4) begin
      bad++;
      $display("FAIL timeout_win: gs=%0d A=%0d phase=%0d, want 1/2/4", game_state, scoreA, phase);
    end
    ticks(2);
    total++;
    if (match_over !== 1'b1 || phase !== 3'd5 || timer !== 7'd0 || game_state !== 2'b01) begin
      bad++;
      $display("FAIL match_end: mo=%0d phase=%0d timer=%0d gs=%0d, want 1/5/0/1",
               match_over, phase, timer, game_state);
    end
    ticks(3);
    total++;
    if (phase !== 3'd5 || timer !== 7'd0) begin
      bad++;
      $display("FAIL match_hold: phase=%0d timer=%0d, want 5/0", phase, timer);
    end
    healthB = 2'd3;
    pulse_start();
    total++;
    if (scoreA !== 2'd0 || scoreB !== 2'd0 || arena_rst !== 1'b1 || match_over !== 1'b0 || game_state !== 2'b00) begin
      bad++;
      $display("FAIL rematch: A=%0d B=%0d arena=%0d mo=%0d gs=%0d, want 0/0/1/0/0",
               scoreA, scoreB, arena_rst, match_over, game_state);
    end
  endtask

  task automatic test_reset_mid();
    go_to_play();
    healthB = 2'd0; cyc(); healthB = 2'd3;
    ticks(2);
    go_to_play();
    ticks(RS - 40);
    total++;
    if (timer !== 7'd40 || scoreA !== 2'd1) begin
      bad++;
      $display("FAIL rst_pre: timer=%0d A=%0d, want 40/1", timer, scoreA);
    end
    start = 1'b1;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (play_en !== 1'b0 || phase !== 3'd0 || scoreA !== 2'd0 || timer !== 7'd0) begin
      bad++;
      $display("FAIL rst_async: play=%0d phase=%0d A=%0d timer=%0d, want 0/0/0/0",
               play_en, phase, scoreA, timer);
    end
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    total++;
    if (phase !== 3'd0 || arena_rst !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_edge: phase=%0d arena=%0d, want 0/0", phase, arena_rst);
    end
    start = 1'b0;
    cyc();
  endtask

  task automatic test_pause();
    pulse_start();
    go_to_play();
    ticks(RS - 50);
    total++;
    if (timer !== 7'd50) begin
      bad++;
      $display("FAIL pause_pre: timer=%0d want 50", timer);
    end
    pulse_start();
`ifdef MATCH_SEQUENCER_PAUSE_EN
    total++;
    if (phase !== 3'd6 || play_en !== 1'b0) begin
      bad++;
      $display("FAIL pause_enter: phase=%0d play=%0d, want 6/0", phase, play_en);
    end
    ticks(5);
    total++;
    if (timer !== 7'd50 || play_en !== 1'b0) begin
      bad++;
      $display("FAIL pause_frozen: timer=%0d play=%0d, want 50/0", timer, play_en);
    end
    pulse_start();
`endif
    total++;
    if (phase !== 3'd3 || play_en !== 1'b1 || timer !== 7'd50) begin
      bad++;
      $display("FAIL pause_play: phase=%0d play=%0d timer=%0d, want 3/1/50", phase, play_en, timer);
    end
    ticks(1);
    total++;
    if (timer !== 7'd49) begin
      bad++;
      $display("FAIL pause_resume_tick: timer=%0d want 49", timer);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      healthA  = ($urandom_range(0, 149) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      healthB  = ($urandom_range(0, 149) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      sec_tick = 1'($urandom_range(0, 1));
      start    = ($urandom_range(0, 24) == 0);
      cyc();
      total++;
      if (phase !== 3'(mPhase)) begin
        bad++; $display("FAIL rnd_phase @%0d: got %0d want %0d", i, phase, mPhase);
      end
      total++;
      if (timer !== 7'(mTimer)) begin
        bad++; $display("FAIL rnd_timer @%0d: got %0d want %0d", i, timer, mTimer);
      end
      total++;
      if (game_state !== 2'(mGs)) begin
        bad++; $display("FAIL rnd_gs @%0d: got %0d want %0d", i, game_state, mGs);
      end
      total++;
      if (scoreA !== 2'(mA) || scoreB !== 2'(mB)) begin
        bad++; $display("FAIL rnd_score @%0d: got %0d/%0d want %0d/%0d", i, scoreA, scoreB, mA, mB);
      end
      total++;
      if (arena_rst !== (mPhase == 1) || play_en !== (mPhase == 3) || match_over !== (mPhase == 5)) begin
        bad++;
        $display("FAIL rnd_flags @%0d: arena/play/mo got %0d%0d%0d for model phase %0d",
                 i, arena_rst, play_en, match_over, mPhase);
      end
    end
    start = 1'b0; sec_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_clear();
    test_knockout();
    test_double_ko();
    test_timeout_match();
    test_reset_mid();
    test_pause();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
